// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus: widths, FSM encoding,
// module ids and the address-field split.
package fx_pkg;

  localparam int FX_AW = 16;
  localparam int FX_DW = 16;

  // addr[15:10] selects the slave, addr[9:0] is the register offset
  localparam int MOD_ID_MSB = 15;
  localparam int MOD_ID_LSB = 10;

  localparam logic [5:0] MOD_FETCH = 6'h21;
  localparam logic [5:0] MOD_COMMU = 6'h22;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } fx_state_t;

  function automatic logic [5:0] mod_id(input logic [FX_AW-1:0] addr);
    return addr[MOD_ID_MSB:MOD_ID_LSB];
  endfunction

endpackage

// File: rtl/fx_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, on a tie the
// requester that did not win last time gets the bus.
module fx_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_idx
);

  // pure combinational selection; the FSM decides when to honour it
  always_comb begin
    grant_vld = req0 | req1;
    grant_idx = (req0 && req1) ? ~last_grant : req1;
  end

endmodule

// File: rtl/fx_bus_arb.sv
// Master-side controller for the shared fx register bus. Two requesters
// are granted round-robin; each grant runs one single-word write or read.
//
// Handshake: a requester raises mN_req with mN_wr/mN_addr/mN_wdata and
// holds them until mN_ack. Fields are captured when the grant is made in
// IDLE, so changes after that are ignored. mN_ack is a one-cycle pulse and
// mN_rdata is valid with it for reads; a dropped req does not cancel a
// granted transaction.
module fx_bus_arb
  import fx_pkg::*;
#(
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q,
  output logic          busy,
  output fx_state_t     state_dbg
);

  // RD_LAT is limited to 1..15, so the wait count always fits in 4 bits
  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

  fx_state_t     state;
  logic          last_grant;
  logic          sel;
  logic [3:0]    cnt;

  logic          grant_vld;
  logic          grant_idx;
  logic          win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  assign state_dbg = state;

  fx_rr_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  // route the winning requester's fields toward the latch point
  always_comb begin
    win_wr    = grant_idx ? m1_wr    : m0_wr;
    win_addr  = grant_idx ? m1_addr  : m0_addr;
    win_wdata = grant_idx ? m1_wdata : m0_wdata;
  end

  // bus sequencer; strobes are set on entry to WR/RD so they are visible
  // exactly while the FSM sits in those states
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      cnt        <= 4'd0;
      busy       <= 1'b0;
      fx_wr      <= 1'b0;
      fx_waddr   <= '0;
      fx_data    <= '0;
      fx_rd      <= 1'b0;
      fx_raddr   <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            sel        <= grant_idx;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            if (win_wr) begin
              fx_wr    <= 1'b1;
              fx_waddr <= win_addr;
              fx_data  <= win_wdata;
              state    <= WR;
            end else begin
              fx_rd    <= 1'b1;
              fx_raddr <= win_addr;
              state    <= RD;
            end
          end
        end
        WR: begin
          fx_wr <= 1'b0;
          if (sel) m1_ack <= 1'b1;
          else     m0_ack <= 1'b1;
          state <= DONE;
        end
        RD: begin
          fx_rd <= 1'b0;
          cnt   <= CNT_LOAD;
          state <= RWAIT;
        end
        RWAIT: begin
          if (cnt == 4'd0) begin
            if (sel) begin
              m1_rdata <= fx_q;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= fx_q;
              m0_ack   <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          fx_wr  <= 1'b0;
          fx_rd  <= 1'b0;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench for fx_bus_arb: one instance with RD_LAT=2 and one with
// RD_LAT=1, each behind a small fx slave model.
module tb_fx_bus_arb;
  import fx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic rst;

  // ---------------- instance a (RD_LAT=2) ----------------
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        fx_wr, fx_rd, busy;
  logic [15:0] fx_waddr, fx_data, fx_raddr, fx_q;
  fx_state_t   state_dbg;

  fx_bus_arb #(.AW(16), .DW(16), .RD_LAT(2)) u_dut (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- instance b (RD_LAT=1) ----------------
  logic        b_m0_req, b_m0_wr, b_m1_req, b_m1_wr;
  logic [15:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_ack, b_m1_ack;
  logic [15:0] b_m0_rdata, b_m1_rdata;
  logic        b_fx_wr, b_fx_rd, b_busy;
  logic [15:0] b_fx_waddr, b_fx_data, b_fx_raddr, b_fx_q;
  fx_state_t   b_state_dbg;

  fx_bus_arb #(.AW(16), .DW(16), .RD_LAT(1)) u_dut_b (
    .clk_sys(clk_sys), .rst(rst),
    .m0_req(b_m0_req), .m0_wr(b_m0_wr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_wr(b_m1_wr), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .fx_wr(b_fx_wr), .fx_waddr(b_fx_waddr), .fx_data(b_fx_data),
    .fx_rd(b_fx_rd), .fx_raddr(b_fx_raddr), .fx_q(b_fx_q),
    .busy(b_busy), .state_dbg(b_state_dbg)
  );

  // ---------------- slave models ----------------
  // Mapped slaves answer addr ^ 16'h9A24; anything else reads as 0.
  function automatic logic [15:0] slave_val(input logic [15:0] a);
    if (mod_id(a) == MOD_FETCH || mod_id(a) == MOD_COMMU) return a ^ 16'h9A24;
    return 16'h0000;
  endfunction

  logic [1:0]  a_pipe;
  logic [15:0] a_laddr;
  logic        b_pipe;
  logic [15:0] b_laddr;

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      a_pipe  <= 2'b00;
      a_laddr <= 16'h0;
      b_pipe  <= 1'b0;
      b_laddr <= 16'h0;
    end else begin
      a_pipe <= {a_pipe[0], fx_rd};
      if (fx_rd) a_laddr <= fx_raddr;
      b_pipe <= b_fx_rd;
      if (b_fx_rd) b_laddr <= b_fx_raddr;
    end
  end

  // data is only on the bus in the single cycle RD_LAT after the strobe
  assign fx_q   = a_pipe[1] ? slave_val(a_laddr) : 16'h0000;
  assign b_fx_q = b_pipe    ? slave_val(b_laddr) : 16'h0000;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // bus-wide invariants, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (!rst) begin
      chk("a_strobe_overlap", 32'(fx_wr & fx_rd), 32'h0);
      chk("a_ack_overlap", 32'(m0_ack & m1_ack), 32'h0);
      chk("a_wr_outside_wr", 32'(fx_wr && state_dbg != WR), 32'h0);
      chk("a_rd_outside_rd", 32'(fx_rd && state_dbg != RD), 32'h0);
      chk("b_strobe_overlap", 32'(b_fx_wr & b_fx_rd), 32'h0);
    end
  end

  // ---------------- directed sequence ----------------
  int budget;

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m0_wr = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_wr = 0; b_m1_addr = 0; b_m1_wdata = 0;
    tick(); tick();

    // reset values
    chk("rst_fx_wr", 32'(fx_wr), 32'h0);
    chk("rst_fx_rd", 32'(fx_rd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_m0_ack", 32'(m0_ack), 32'h0);
    chk("rst_m1_ack", 32'(m1_ack), 32'h0);
    chk("rst_m0_rdata", 32'(m0_rdata), 32'h0);
    chk("rst_fx_waddr", 32'(fx_waddr), 32'h0);
    chk("rst_fx_raddr", 32'(fx_raddr), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    tick();

    // m0 write
    m0_req = 1; m0_wr = 1; m0_addr = 16'h8404; m0_wdata = 16'hA5A5;
    tick();
    chk("wr_strobe", 32'(fx_wr), 32'h1);
    chk("wr_waddr", 32'(fx_waddr), 32'h8404);
    chk("wr_data", 32'(fx_data), 32'hA5A5);
    chk("wr_no_rd", 32'(fx_rd), 32'h0);
    chk("wr_early_ack", 32'(m0_ack), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);
    tick();
    chk("wr_strobe_1cyc", 32'(fx_wr), 32'h0);
    chk("wr_ack", 32'(m0_ack), 32'h1);
    chk("wr_m1_ack", 32'(m1_ack), 32'h0);
    m0_req = 0; m0_wr = 0;
    tick();
    chk("wr_ack_1cyc", 32'(m0_ack), 32'h0);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    chk("hold_waddr", 32'(fx_waddr), 32'h8404);
    chk("hold_data", 32'(fx_data), 32'hA5A5);

    // both read requests arrive together after an m0-only grant: m1 first
    m0_req = 1; m0_addr = 16'h8404;
    m1_req = 1; m1_wr = 0; m1_addr = 16'h8810;
    tick();
    chk("sim_rd_strobe", 32'(fx_rd), 32'h1);
    chk("sim_raddr_m1", 32'(fx_raddr), 32'h8810);
    chk("sim_no_wr", 32'(fx_wr), 32'h0);
    tick();
    chk("rd_strobe_1cyc", 32'(fx_rd), 32'h0);
    chk("rd_state_rwait", 32'(state_dbg), 32'(RWAIT));
    tick();
    chk("rd_no_early_ack", 32'(m1_ack), 32'h0);
    tick();
    chk("rd_m1_ack", 32'(m1_ack), 32'h1);
    chk("rd_m1_rdata", 32'(m1_rdata), 32'h1234);
    chk("rd_m0_no_ack", 32'(m0_ack), 32'h0);
    m1_req = 0;
    tick();
    chk("rd_ack_1cyc", 32'(m1_ack), 32'h0);
    chk("rd_back_idle", 32'(state_dbg), 32'(IDLE));
    tick();
    chk("sim2_rd_strobe", 32'(fx_rd), 32'h1);
    chk("sim2_raddr_m0", 32'(fx_raddr), 32'h8404);
    tick(); tick(); tick();
    chk("sim2_m0_ack", 32'(m0_ack), 32'h1);
    chk("sim2_m0_rdata", 32'(m0_rdata), 32'h1E20);
    chk("sim2_m1_rdata_hold", 32'(m1_rdata), 32'h1234);
    m0_req = 0;
    tick();

    // continuous contention from reset: m0, m1, m0, m1
    rst = 1;
    m0_req = 1; m0_wr = 0; m0_addr = 16'h8404;
    m1_req = 1; m1_wr = 0; m1_addr = 16'h8808;
    tick();
    chk("rst_clears_rdata", 32'(m0_rdata), 32'h0);
    rst = 0;
    for (int g = 0; g < 4; g++) begin
      budget = 0;
      while (!(m0_ack || m1_ack) && budget < 20) begin
        tick();
        budget++;
      end
      chk("cont_timeout", 32'(budget < 20), 32'h1);
      chk("cont_m0_ack", 32'(m0_ack), 32'(g % 2 == 0));
      chk("cont_m1_ack", 32'(m1_ack), 32'(g % 2 == 1));
      if (g % 2 == 0) chk("cont_m0_rdata", 32'(m0_rdata), 32'h1E20);
      else            chk("cont_m1_rdata", 32'(m1_rdata), 32'h122C);
      tick();
    end

    // reset asserted during RWAIT
    m1_req = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk("mr_rd_strobe", 32'(fx_rd), 32'h1);
    tick();
    chk("mr_in_rwait", 32'(state_dbg), 32'(RWAIT));
    chk("mr_busy_before", 32'(busy), 32'h1);
    #2;
    rst = 1;
    #1;
    chk("mr_fx_rd", 32'(fx_rd), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_m0_ack", 32'(m0_ack), 32'h0);
    chk("mr_m1_ack", 32'(m1_ack), 32'h0);
    chk("mr_state", 32'(state_dbg), 32'(IDLE));
    tick();
    chk("mr_no_ack_in_rst", 32'(m0_ack), 32'h0);
    rst = 0;
    tick();
    chk("mr_restart_rd", 32'(fx_rd), 32'h1);
    tick(); tick();
    chk("mr_no_spurious_ack", 32'(m0_ack), 32'h0);
    tick();
    chk("mr_restart_ack", 32'(m0_ack), 32'h1);
    chk("mr_restart_rdata", 32'(m0_rdata), 32'h1E20);
    m0_req = 0;
    tick();

    // RD_LAT=1: mapped read, then unmapped read returns 0
    b_m0_req = 1; b_m0_wr = 0; b_m0_addr = 16'h8404;
    tick();
    chk("b_rd_strobe", 32'(b_fx_rd), 32'h1);
    tick();
    chk("b_no_early_ack", 32'(b_m0_ack), 32'h0);
    tick();
    chk("b_ack", 32'(b_m0_ack), 32'h1);
    chk("b_rdata", 32'(b_m0_rdata), 32'h1E20);
    b_m0_req = 0;
    tick();
    b_m0_req = 1; b_m0_addr = 16'h0400;
    tick();
    chk("b_un_strobe", 32'(b_fx_rd), 32'h1);
    chk("b_un_hold1", 32'(b_m0_rdata), 32'h1E20);
    tick();
    chk("b_un_no_early_ack", 32'(b_m0_ack), 32'h0);
    chk("b_un_hold2", 32'(b_m0_rdata), 32'h1E20);
    tick();
    chk("b_un_ack", 32'(b_m0_ack), 32'h1);
    chk("b_un_rdata", 32'(b_m0_rdata), 32'h0);

    // write whose req drops right after the grant still completes
    b_m0_wr = 1; b_m0_addr = 16'h8800; b_m0_wdata = 16'h5A5A;
    tick();
    chk("b_wr_idle_ack", 32'(b_m0_ack), 32'h0);
    tick();
    chk("b_wr_strobe", 32'(b_fx_wr), 32'h1);
    chk("b_wr_waddr", 32'(b_fx_waddr), 32'h8800);
    chk("b_wr_data", 32'(b_fx_data), 32'h5A5A);
    b_m0_req = 0;
    tick();
    chk("b_wr_drop_ack", 32'(b_m0_ack), 32'h1);
    tick();
    chk("b_wr_idle", 32'(b_busy), 32'h0);
    chk("b_m1_never_ack", 32'(b_m1_ack), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx_bus_arb.md
Name: fx_bus_arb

Overview:
- Master-side controller for the shared fx register bus that reaches every fx slave (fetch block mod_id 6'h21, commu block mod_id 6'h22).
- Accepts read/write requests from two requesters and grants the bus round-robin:
  - m0 is the ARM SPI command path.
  - m1 is the sync-driven status poller.
- Sequences single-word fx write and read cycles with a fixed read latency and returns read data with a one-cycle ack.
- Sits in top_m between the requesters and the fx_* nets, which are currently tied off.

Parameters:
- AW, 16, fx address width; addr[15:10] is mod_id, addr[9:0] is the register offset.
- DW, 16, fx data width.
- RD_LAT, 2, cycles from the fx_rd pulse to valid fx_q; legal range 1..15.

Ports:
- clk_sys  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  request from requester 0; held with its fields until m0_ack.
- m0_wr  in  1  1 = write, 0 = read.
- m0_addr  in  AW  target address.
- m0_wdata  in  DW  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data; valid when m0_ack=1.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to the m0 ports, for requester 1.
- fx_wr  out  1  fx write strobe.
- fx_waddr  out  AW  fx write address.
- fx_data  out  DW  fx write data.
- fx_rd  out  1  fx read strobe.
- fx_raddr  out  AW  fx read address.
- fx_q  in  DW  OR-combined slave read data; unaddressed slaves drive 0.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock, clk_sys; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, last_grant=1 (so m0 wins first), latency counter 0.
- Reset asserted mid-transaction: all outputs drop to 0 immediately and no ack is issued. After reset releases, a still-asserted request restarts from IDLE.
- All outputs are registered.

FSM states: IDLE, WR, RD, RWAIT, DONE.
- IDLE:
  - If any req is high, select a winner:
    - Only one req high: that requester wins.
    - Both high: the requester that is not last_grant wins.
  - Latch the winner's wr/addr/wdata and set last_grant to the winner.
  - Next state: WR if wr=1, else RD.
- WR:
  - fx_wr=1 for exactly one cycle, with fx_waddr=addr and fx_data=wdata.
  - Next state: DONE.
- RD:
  - fx_rd=1 for exactly one cycle, with fx_raddr=addr; counter loads RD_LAT-1.
  - Next state: RWAIT.
- RWAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture fx_q into the winner's rdata register; next state DONE.
  - Capture therefore happens in the cycle RD_LAT after the fx_rd cycle.
- DONE:
  - Winner's ack=1 for one cycle (with rdata for reads); next state IDLE.
  - Requests are not sampled in DONE. A requester may keep req high to issue back-to-back transactions.
- Latency from req sampled in IDLE at cycle t:
  - Write: fx_wr at t+1, ack at t+2.
  - Read: fx_rd at t+1, ack at t+2+RD_LAT.
- Request holding and drop rules:
  - A requester must hold req and its fields stable until ack.
  - Fields are latched in IDLE, so later changes have no effect.
  - If req drops mid-transaction, the transaction still completes and ack is still pulsed.
- Fairness: with both reqs continuously high, grants strictly alternate (m0, m1, m0, ...); the bus is idle for one cycle (IDLE) between transactions.
- Output hold values:
  - fx_waddr, fx_data and fx_raddr keep their last driven value between strobes.
  - m0_rdata and m1_rdata hold until that requester's next read completes.
- Unmapped address: the bus returns fx_q=0 and 0 is returned with a normal ack; there is no error signalling.
- fx_wr and fx_rd are never high in the same cycle, and never high outside WR/RD.

Decomposition:
- Shared package fx_pkg holds:
  - FX_AW and FX_DW.
  - The fx_state_t encoding (IDLE=0, WR=1, RD=2, RWAIT=3, DONE=4).
  - Module id constants MOD_FETCH=6'h21 and MOD_COMMU=6'h22.
  - The address-field split (MOD_ID_MSB=15, MOD_ID_LSB=10).
- One natural sub-module, fx_rr_pick: combinational 2-way round-robin picker taking (req0, req1, last_grant) and producing (grant_vld, grant_idx). The FSM and datapath stay in fx_bus_arb.

Test Plan:
- Write: m0_req, m0_wr=1, m0_addr=16'h8404, m0_wdata=16'hA5A5 at cycle t -> fx_wr=1 with fx_waddr=16'h8404, fx_data=16'hA5A5 at t+1 only; m0_ack at t+2; fx_rd stays 0.
- Read, RD_LAT=2: m1 read of 16'h8810, slave model drives fx_q=16'h1234 two cycles after fx_rd -> fx_rd at t+1, m1_ack at t+4 with m1_rdata=16'h1234; m0_ack stays 0.
- Contention: m0 and m1 both request reads continuously from reset -> grants in order m0, m1, m0, m1; each ack goes only to its owner; no two strobes overlap.
- Simultaneous arrival after an m0-only transaction: both reqs rise in the same IDLE cycle -> m1 is granted first.
- Reset mid-read: rst pulses during RWAIT -> fx_rd, busy and both acks are 0 immediately with no spurious ack; with m0_req still high after release, a fresh read completes normally.
- Unmapped read with RD_LAT=1: fx_q=0 -> ack at t+3 with rdata=0; m0_rdata retains its prior value until overwritten.
